i1_req_scheduler: RTL and testbench
===================================

// Module: i1_req_scheduler
// PURPOSE
//  Sequences the i1 request/status datapath. Samples the seven V7-style request lines and
//  grants exactly one requester at a time, in fixed-priority or round-robin order.
//  Holds each grant until the owner acknowledges it or a timeout expires.
//  Sits ahead of the i1 decode logic and drives its select and enable inputs from a registered grant.
// PARAMETERS
//  NREQ     7   number of request lines (1..8)
//  TMO      15  cycles a grant may stay unacknowledged before it is revoked (1..2**CW-1)
//  CW       4   timeout counter width
// PORTS
//  clock         in   1     single system clock, rising edge
//  reset         in   1     synchronous, active-high
//  en            in   1     global enable (IN-V29 role); low = no new grants, abort current
//  mode          in   1     0 = fixed priority (index 0 highest), 1 = round-robin
//  req           in   NREQ  request lines, level-sensitive
//  ack           in   1     owner acknowledge, single-cycle pulse
//  grant_valid   out  1     grant asserted
//  grant_id      out  3     index of granted line; 0 when not valid
//  grant_oh      out  NREQ  one-hot grant; all zero when not valid
//  quiet         out  1     registered: en & ~|req (the all-lines-idle flag)
//  timeout_err   out  1     one-cycle pulse when a grant is revoked by timeout
// BEHAVIOUR
//  Reset: state=IDLE; grant_valid=0, grant_id=0, grant_oh=0, quiet=0, timeout_err=0,
//   rr_ptr=0, tcnt=0. Reset mid-grant drops the grant on the same edge; no err pulse.
//  States: IDLE, GRANT, RELEASE.
//  IDLE: if en & |req, pick a winner and enter GRANT. grant_valid rises on the next edge,
//   so latency is 1 cycle from sampled req. ack is ignored in IDLE.
//  Winner selection:
//   mode 0 = lowest set index.
//   mode 1 = first set index at or after rr_ptr, wrapping NREQ-1 -> 0.
//  GRANT: grant_id/grant_oh are held stable; req dropping does not release the grant.
//   tcnt increments each cycle without ack.
//   ack -> RELEASE; rr_ptr <= (id==NREQ-1) ? 0 : id+1.
//   tcnt==TMO without ack -> RELEASE; timeout_err pulses with the drop edge.
//    rr_ptr advances past the offender as above, in both modes.
//   ack on the same cycle as tcnt==TMO: ack wins, no timeout_err.
//   en low -> RELEASE; no pointer update, no err. en has priority over ack and timeout.
//  RELEASE: grant outputs are 0 for exactly one cycle (bus turnaround); tcnt cleared; -> IDLE.
//   Back-to-back grants to the same line are therefore at least 2 cycles apart.
//  mode changes are sampled only in IDLE; a mode change mid-GRANT takes effect at the next pick.
//  quiet is updated every cycle regardless of state.
//  grant_oh == (1 << grant_id) whenever grant_valid=1.
// STRUCTURE
//  Package i1_sched_pkg:
//   - state enum (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2)
//   - ID_W=3 constant
//   - function wrap_inc(id, n)
//  Sub-module i1_rr_pick: combinational rotating-base priority encoder
//   (req, base, mode -> found, idx). Used once, in IDLE.
//  Top level holds the FSM, tcnt, rr_ptr and the output registers.
// TESTING
//  1 Fixed priority: mode=0, req=7'b1010100 -> grant_id=2 one cycle later; ack -> 1 zero cycle, then id=4.
//  2 Round-robin: mode=1, req=7'h7F held, ack every grant -> ids 0,1,2,...,6,0; 2-cycle spacing.
//  3 Timeout: grant id=3, no ack -> after 15 unacked cycles timeout_err=1 for 1 cycle,
//    grant drops, and with mode=1 the next grant is id=4.
//  4 Ack/timeout tie: ack on the cycle tcnt==15 -> no timeout_err, normal release.
//  5 Abort and reset: en low mid-grant -> grant drops, rr_ptr unchanged.
//    reset mid-grant -> all outputs 0 next edge; after release, req=0, en=1 -> quiet=1.

Source files
------------

// File: rtl/i1_sched_pkg.sv
// Shared types and helpers for the i1 request scheduler.
// State encoding is fixed so the debug state output decodes the same way everywhere.
package i1_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int ID_W = 3;

    // Next index after id in a ring of n lines (n-1 wraps to 0).
    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] id, input int n);
        if (int'(id) >= n - 1) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

endpackage

// File: rtl/i1_rr_pick.sv
// Rotating-base priority encoder: returns the first set request at or after the base,
// wrapping past the top line. With mode=0 the base is forced to 0 (plain fixed priority).
module i1_rr_pick
    import i1_sched_pkg::*;
#(
    parameter int NREQ = 7
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] base,
    input  logic            mode,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    always_comb begin
        int start;
        int cand;
        logic [ID_W-1:0] cand_idx;
        found    = 1'b0;
        idx      = '0;
        start    = mode ? int'(base) : 0;
        cand     = 0;
        cand_idx = '0;
        // Walk offsets from far to near so the nearest hit is the one left standing.
        for (int off = NREQ - 1; off >= 0; off--) begin
            cand = start + off;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = ID_W'(cand);
            if (req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/i1_req_scheduler.sv
// Grants one of NREQ request lines at a time (fixed priority or round-robin), holds the
// grant until ack or timeout, and inserts a one-cycle turnaround between grants.
module i1_req_scheduler
    import i1_sched_pkg::*;
#(
    parameter int NREQ = 7,
    parameter int TMO  = 15,
    parameter int CW   = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            en,
    input  logic            mode,
    input  logic [NREQ-1:0] req,
    input  logic            ack,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_id,
    output logic [NREQ-1:0] grant_oh,
    output logic            quiet,
    output logic            timeout_err,
    output logic [1:0]      dbg_state
);

    // Handshake: grant_valid/grant_id/grant_oh are registered and held stable from the edge
    // they rise until the edge after the owner's single-cycle ack (or timeout / en low);
    // ack is only meaningful while grant_valid=1 and is ignored otherwise.

    state_t          state_q, state_d;
    logic            gv_q, gv_d;
    logic [ID_W-1:0] gid_q, gid_d;
    logic [NREQ-1:0] goh_q, goh_d;
    logic [CW-1:0]   tcnt_q, tcnt_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic            terr_q, terr_d;
    logic            quiet_q;

    logic            pick_found;
    logic [ID_W-1:0] pick_idx;

    i1_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req   (req),
        .base  (rr_ptr_q),
        .mode  (mode),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        gv_d     = gv_q;
        gid_d    = gid_q;
        goh_d    = goh_q;
        tcnt_d   = tcnt_q;
        rr_ptr_d = rr_ptr_q;
        terr_d   = 1'b0;

        case (state_q)
            // The turnaround cycle is also a pick cycle, so a pending request is granted
            // after exactly one zero cycle instead of two.
            IDLE, RELEASE: begin
                tcnt_d  = '0;
                gv_d    = 1'b0;
                gid_d   = '0;
                goh_d   = '0;
                state_d = IDLE;
                if (en && pick_found) begin
                    state_d = GRANT;
                    gv_d    = 1'b1;
                    gid_d   = pick_idx;
                    goh_d   = NREQ'(1) << pick_idx;
                end
            end
            GRANT: begin
                if (!en) begin
                    state_d = RELEASE;
                    gv_d    = 1'b0;
                    gid_d   = '0;
                    goh_d   = '0;
                end else if (ack || (tcnt_q == CW'(TMO))) begin
                    state_d  = RELEASE;
                    gv_d     = 1'b0;
                    gid_d    = '0;
                    goh_d    = '0;
                    rr_ptr_d = wrap_inc(gid_q, NREQ);
                    terr_d   = !ack;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gv_d    = 1'b0;
                gid_d   = '0;
                goh_d   = '0;
                tcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            gv_q     <= 1'b0;
            gid_q    <= '0;
            goh_q    <= '0;
            tcnt_q   <= '0;
            rr_ptr_q <= '0;
            terr_q   <= 1'b0;
            quiet_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gv_q     <= gv_d;
            gid_q    <= gid_d;
            goh_q    <= goh_d;
            tcnt_q   <= tcnt_d;
            rr_ptr_q <= rr_ptr_d;
            terr_q   <= terr_d;
            quiet_q  <= en & ~|req;
        end
    end

    assign grant_valid = gv_q;
    assign grant_id    = gid_q;
    assign grant_oh    = goh_q;
    assign quiet       = quiet_q;
    assign timeout_err = terr_q;
    assign dbg_state   = state_q;

    a_oh_matches_id: assert property (@(posedge clock) disable iff (reset)
        grant_valid |-> (grant_oh == (NREQ'(1) << grant_id)));
    a_idle_zero: assert property (@(posedge clock) disable iff (reset)
        !grant_valid |-> (grant_oh == '0 && grant_id == '0));
    a_err_no_grant: assert property (@(posedge clock) disable iff (reset)
        timeout_err |-> !grant_valid);

endmodule

// File: tb/tb_i1_req_scheduler.sv
// Scenario bench for i1_req_scheduler: expected grant ids go into exp_q when requests are
// driven and are popped when the grant appears.
module tb_i1_req_scheduler;

    logic       clock = 1'b0;
    logic       reset;
    logic       en;
    logic       mode;
    logic [6:0] req;
    logic       ack;
    logic       grant_valid;
    logic [2:0] grant_id;
    logic [6:0] grant_oh;
    logic       quiet;
    logic       timeout_err;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_id;
    logic [2:0] model_ptr;

    i1_req_scheduler #(
        .NREQ (7),
        .TMO  (15),
        .CW   (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .en          (en),
        .mode        (mode),
        .req         (req),
        .ack         (ack),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .grant_oh    (grant_oh),
        .quiet       (quiet),
        .timeout_err (timeout_err),
        .dbg_state   (dbg_state)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    // One cycle: outputs are looked at 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en    = 1'b0;
        mode  = 1'b0;
        req   = '0;
        ack   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        model_ptr = '0;
    endtask

    function automatic logic [2:0] model_pick(input logic [6:0] r, input logic m, input logic [2:0] p);
        int s;
        int c;
        s = m ? int'(p) : 0;
        for (int k = 0; k < 7; k++) begin
            c = (s + k) % 7;
            if (r[c]) return 3'(c);
        end
        return 3'd0;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b1;
        mode  = 1'b0;
        req   = '0;
        ack   = 1'b0;
        tick();
        tick();
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", grant_valid); end
        checks++; if (grant_id !== 3'd0) begin errors++; $display("FAIL rst_id: got %0d expected 0", grant_id); end
        checks++; if (grant_oh !== 7'd0) begin errors++; $display("FAIL rst_oh: got %b expected 0", grant_oh); end
        checks++; if (quiet !== 1'b0) begin errors++; $display("FAIL rst_quiet: got %b expected 0", quiet); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_terr: got %b expected 0", timeout_err); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
        reset = 1'b0;
        en    = 1'b0;
        model_ptr = '0;
    endtask

    task automatic test_fixed_priority();
        do_reset();
        mode = 1'b0;
        en   = 1'b1;
        req  = 7'b1010100;
        exp_q.push_back(3'd2);
        tick();
        exp_id = exp_q.pop_front();
        checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL fix_latency: got %b expected 1", grant_valid); end
        checks++; if (grant_id !== exp_id) begin errors++; $display("FAIL fix_id_first: got %0d expected %0d", grant_id, exp_id); end
        checks++; if (grant_oh !== 7'b0000100) begin errors++; $display("FAIL fix_oh_first: got %b expected 0000100", grant_oh); end
        ack = 1'b1;
        req = 7'b1010000;
        exp_q.push_back(3'd4);
        tick();
        ack = 1'b0;
        checks++; if (grant_valid !== 1'b0 || grant_oh !== 7'd0) begin errors++; $display("FAIL fix_gap: got v=%b oh=%b expected v=0 oh=0", grant_valid, grant_oh); end
        tick();
        exp_id = exp_q.pop_front();
        checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL fix_second_valid: got %b expected 1", grant_valid); end
        checks++; if (grant_id !== exp_id) begin errors++; $display("FAIL fix_id_second: got %0d expected %0d", grant_id, exp_id); end
        checks++; if (grant_oh !== 7'b0010000) begin errors++; $display("FAIL fix_oh_second: got %b expected 0010000", grant_oh); end
    endtask

    task automatic test_round_robin();
        do_reset();
        mode = 1'b1;
        en   = 1'b1;
        req  = 7'h7F;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(3'(k % 7));
        end
        tick();
        for (int k = 0; k < 8; k++) begin
            exp_id = exp_q.pop_front();
            checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d]: got %b expected 1", k, grant_valid); end
            checks++; if (grant_id !== exp_id) begin errors++; $display("FAIL rr_id[%0d]: got %0d expected %0d", k, grant_id, exp_id); end
            checks++; if (grant_oh !== (7'd1 << exp_id)) begin errors++; $display("FAIL rr_oh[%0d]: got %b expected %b", k, grant_oh, 7'd1 << exp_id); end
            ack = 1'b1;
            tick();
            ack = 1'b0;
            checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rr_gap[%0d]: got %b expected 0", k, grant_valid); end
            tick();
        end
    endtask

    task automatic test_timeout();
        do_reset();
        mode = 1'b1;
        en   = 1'b1;
        req  = 7'b0011000;
        exp_q.push_back(3'd3);
        tick();
        exp_id = exp_q.pop_front();
        checks++; if (grant_valid !== 1'b1 || grant_id !== exp_id) begin errors++; $display("FAIL tmo_first: got v=%b id=%0d expected v=1 id=%0d", grant_valid, grant_id, exp_id); end
        for (int i = 0; i < 15; i++) begin
            checks++; if (grant_valid !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_hold[%0d]: got v=%b err=%b expected v=1 err=0", i, grant_valid, timeout_err); end
            tick();
        end
        checks++; if (grant_valid !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_last_cycle: got v=%b err=%b expected v=1 err=0", grant_valid, timeout_err); end
        exp_q.push_back(3'd4);
        tick();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_pulse: got %b expected 1", timeout_err); end
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL tmo_drop: got %b expected 0", grant_valid); end
        tick();
        exp_id = exp_q.pop_front();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width: got %b expected 0", timeout_err); end
        checks++; if (grant_valid !== 1'b1 || grant_id !== exp_id) begin errors++; $display("FAIL tmo_next: got v=%b id=%0d expected v=1 id=%0d", grant_valid, grant_id, exp_id); end
    endtask

    task automatic test_ack_timeout_tie();
        do_reset();
        mode = 1'b0;
        en   = 1'b1;
        req  = 7'b0000010;
        exp_q.push_back(3'd1);
        tick();
        exp_id = exp_q.pop_front();
        checks++; if (grant_valid !== 1'b1 || grant_id !== exp_id) begin errors++; $display("FAIL tie_first: got v=%b id=%0d expected v=1 id=%0d", grant_valid, grant_id, exp_id); end
        for (int i = 0; i < 15; i++) tick();
        checks++; if (grant_valid !== 1'b1) begin errors++; $display("FAIL tie_hold: got %b expected 1", grant_valid); end
        ack = 1'b1;
        exp_q.push_back(3'd1);
        tick();
        ack = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tie_no_err: got %b expected 0", timeout_err); end
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL tie_drop: got %b expected 0", grant_valid); end
        tick();
        exp_id = exp_q.pop_front();
        checks++; if (grant_valid !== 1'b1 || grant_id !== exp_id || timeout_err !== 1'b0) begin errors++; $display("FAIL tie_regrant: got v=%b id=%0d err=%b expected v=1 id=%0d err=0", grant_valid, grant_id, timeout_err, exp_id); end
    endtask

    task automatic test_en_gating();
        do_reset();
        mode = 1'b0;
        en   = 1'b0;
        req  = 7'b0010010;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (grant_valid !== 1'b0 || quiet !== 1'b0) begin errors++; $display("FAIL en_off[%0d]: got v=%b q=%b expected v=0 q=0", i, grant_valid, quiet); end
        end
        en  = 1'b1;
        req = '0;
        tick();
        checks++; if (quiet !== 1'b1 || grant_valid !== 1'b0) begin errors++; $display("FAIL quiet_idle: got q=%b v=%b expected q=1 v=0", quiet, grant_valid); end
        req = 7'b0010010;
        exp_q.push_back(3'd1);
        tick();
        exp_id = exp_q.pop_front();
        checks++; if (quiet !== 1'b0) begin errors++; $display("FAIL quiet_busy: got %b expected 0", quiet); end
        checks++; if (grant_valid !== 1'b1 || grant_id !== exp_id) begin errors++; $display("FAIL en_on_grant: got v=%b id=%0d expected v=1 id=%0d", grant_valid, grant_id, exp_id); end
    endtask

    task automatic test_abort_and_reset();
        do_reset();
        mode = 1'b1;
        en   = 1'b1;
        req  = 7'b0100000;
        exp_q.push_back(3'd5);
        tick();
        exp_id = exp_q.pop_front();
        checks++; if (grant_valid !== 1'b1 || grant_id !== exp_id) begin errors++; $display("FAIL abort_first: got v=%b id=%0d expected v=1 id=%0d", grant_valid, grant_id, exp_id); end
        tick();
        tick();
        en = 1'b0;
        tick();
        checks++; if (grant_valid !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL abort_drop: got v=%b err=%b expected v=0 err=0", grant_valid, timeout_err); end
        checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL abort_state: got %0d expected 2", dbg_state); end
        en  = 1'b1;
        req = 7'h7F;
        exp_q.push_back(3'd0);
        tick();
        exp_id = exp_q.pop_front();
        checks++; if (grant_valid !== 1'b1 || grant_id !== exp_id) begin errors++; $display("FAIL abort_ptr_kept: got v=%b id=%0d expected v=1 id=%0d", grant_valid, grant_id, exp_id); end
        reset = 1'b1;
        tick();
        checks++; if (grant_valid !== 1'b0 || grant_id !== 3'd0 || grant_oh !== 7'd0) begin errors++; $display("FAIL midrst_grant: got v=%b id=%0d oh=%b expected all 0", grant_valid, grant_id, grant_oh); end
        checks++; if (timeout_err !== 1'b0 || quiet !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL midrst_misc: got err=%b q=%b st=%0d expected 0 0 0", timeout_err, quiet, dbg_state); end
        reset = 1'b0;
        req   = '0;
        en    = 1'b1;
        tick();
        checks++; if (quiet !== 1'b1 || grant_valid !== 1'b0) begin errors++; $display("FAIL post_rst_quiet: got q=%b v=%b expected q=1 v=0", quiet, grant_valid); end
    endtask

    task automatic test_random();
        logic [6:0] r;
        logic       m;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            r    = 7'($urandom_range(1, 127));
            m    = 1'($urandom_range(0, 1));
            req  = r;
            mode = m;
            exp_q.push_back(model_pick(r, m, model_ptr));
            tick();
            exp_id = exp_q.pop_front();
            checks++; if (grant_valid !== 1'b1 || grant_id !== exp_id) begin errors++; $display("FAIL rand_grant[%0d]: got v=%b id=%0d expected v=1 id=%0d (req=%b mode=%b)", k, grant_valid, grant_id, exp_id, r, m); end
            checks++; if (grant_oh !== (7'd1 << exp_id)) begin errors++; $display("FAIL rand_oh[%0d]: got %b expected %b", k, grant_oh, 7'd1 << exp_id); end
            model_ptr = (exp_id == 3'd6) ? 3'd0 : exp_id + 3'd1;
            ack = 1'b1;
            req = '0;
            tick();
            ack = 1'b0;
            checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL rand_gap[%0d]: got %b expected 0", k, grant_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_timeout();
        test_ack_timeout_tie();
        test_en_gating();
        test_abort_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
